sdram_wr_burst_sched: RTL and testbench

Read-side scheduler for the SDRAM write-path async FIFO, running in the FIFO read clock domain. It watches the FIFO fill level and decides when to start a burst: a full burst at threshold, or a partial burst on idle timeout or flush. It requests the SDRAM write port, then pops exactly the granted word count from the FIFO into the controller. It also maintains a wrapping write address and flags protocol errors.

---
 rtl/sdram_wr_pkg.sv | 30 +++
 rtl/sdram_wr_addr_gen.sv | 37 +++
 rtl/sdram_wr_burst_sched.sv | 152 +++++++++++++++
 tb/tb_sdram_wr_burst_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wr_pkg.sv
// rtl/sdram_wr_pkg.sv - shared widths, FSM state codes and ring-address helper
package sdram_wr_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NUM_W  = 8;
   localparam int DEF_ADDR_W = 24;
   localparam int RING_W     = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_XFER = 2'd2;

   // Next start address after a burst of len words, wrapped modulo the [base, top] region.
   function automatic logic [RING_W-1:0] ring_next(
      input logic [RING_W-1:0] addr,
      input logic [RING_W-1:0] len,
      input logic [RING_W-1:0] base,
      input logic [RING_W-1:0] top
   );
      logic [RING_W:0] sum;
      sum = {1'b0, addr} + {1'b0, len};
      if (sum > {1'b0, top}) begin
         sum = {1'b0, base} + sum - {1'b0, top} - {{RING_W{1'b0}}, 1'b1};
      end
      return sum[RING_W-1:0];
   endfunction

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// rtl/sdram_wr_addr_gen.sv - ring write-address register, advanced by burst length on completion
module sdram_wr_addr_gen
   import sdram_wr_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                NUM_W     = DEF_NUM_W,
   parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
   parameter logic [ADDR_W-1:0] ADDR_TOP  = '1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              advance_i,
   input  logic [NUM_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (advance_i) begin
         addr_d = ADDR_W'(ring_next(RING_W'(addr_q), RING_W'(len_i),
                                    RING_W'(ADDR_BASE), RING_W'(ADDR_TOP)));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         addr_q <= ADDR_BASE;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/sdram_wr_burst_sched.sv
// rtl/sdram_wr_burst_sched.sv - FIFO read-side burst scheduler feeding the SDRAM write port
module sdram_wr_burst_sched
   import sdram_wr_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                NUM_W     = DEF_NUM_W,
   parameter int                BURST_LEN = 8,
   parameter int                TIMEOUT   = 64,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
   parameter logic [ADDR_W-1:0] ADDR_TOP  = '1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              enable_i,
   input  logic              flush_i,
   input  logic              fifo_empty_i,
   input  logic [NUM_W-1:0]  fifo_data_num_i,
   input  logic              fifo_underrun_i,
   output logic              fifo_rd_en_o,
   input  logic [DATA_W-1:0] fifo_rd_data_i,
   output logic              sdram_wr_req_o,
   input  logic              sdram_wr_ack_i,
   output logic [ADDR_W-1:0] sdram_wr_addr_o,
   output logic [NUM_W-1:0]  sdram_wr_len_o,
   input  logic              sdram_wr_data_req_i,
   output logic [DATA_W-1:0] sdram_wr_data_o,
   output logic              sdram_wr_data_vld_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
   localparam logic [NUM_W-1:0] BL       = NUM_W'(BURST_LEN);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [NUM_W-1:0]  len_q, len_d;
   logic [NUM_W-1:0]  rem_q, rem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              flush_q, flush_d;
   logic              vld_q;
   logic              err_q, err_d;
   logic              rd_en;
   logic              flush_eff;
   logic              advance;
   logic [ADDR_W-1:0] ring_addr;

   assign rd_en     = (state_q == ST_XFER) && sdram_wr_data_req_i && (rem_q != '0);
   assign flush_eff = flush_q | flush_i;
   // The burst is finished once every word is popped and the last one has been presented.
   assign advance   = (state_q == ST_XFER) && (rem_q == '0) && vld_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      tmr_d   = tmr_q;
      flush_d = flush_eff;
      case (state_q)
         ST_IDLE: begin
            if (!enable_i) begin
               tmr_d = '0;
            end else if (fifo_data_num_i >= BL) begin
               state_d = ST_REQ;
               len_d   = BL;
               rem_d   = BL;
               addr_d  = ring_addr;
            end else if ((flush_eff || (tmr_q == TMR_LAST)) && (fifo_data_num_i != '0)) begin
               state_d = ST_REQ;
               len_d   = fifo_data_num_i;
               rem_d   = fifo_data_num_i;
               addr_d  = ring_addr;
               tmr_d   = '0;
               flush_d = 1'b0;
            end else if (fifo_data_num_i != '0) begin
               tmr_d = tmr_q + 1'b1;
            end else begin
               tmr_d   = '0;
               flush_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (sdram_wr_ack_i) begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (rd_en) begin
               rem_d = rem_q - 1'b1;
            end
            if (advance) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Empty-pop is flagged but not suppressed; the FIFO decides what it returns.
   assign err_d = err_q | fifo_underrun_i | (rd_en & fifo_empty_i)
                | (sdram_wr_ack_i & (state_q != ST_REQ));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         tmr_q   <= '0;
         flush_q <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         tmr_q   <= tmr_d;
         flush_q <= flush_d;
         vld_q   <= rd_en;
         err_q   <= err_d;
      end
   end

   sdram_wr_addr_gen #(
      .ADDR_W    (ADDR_W),
      .NUM_W     (NUM_W),
      .ADDR_BASE (ADDR_BASE),
      .ADDR_TOP  (ADDR_TOP)
   ) u_addr_gen (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .advance_i (advance),
      .len_i     (len_q),
      .addr_o    (ring_addr)
   );

   assign fifo_rd_en_o        = rd_en;
   assign sdram_wr_req_o      = (state_q == ST_REQ);
   assign sdram_wr_addr_o     = addr_q;
   assign sdram_wr_len_o      = len_q;
   assign sdram_wr_data_o     = fifo_rd_data_i;
   assign sdram_wr_data_vld_o = vld_q;
   assign busy_o              = (state_q != ST_IDLE);
   assign err_o               = err_q;

endmodule

// File: tb/tb_sdram_wr_burst_sched.sv
// tb/tb_sdram_wr_burst_sched.sv - self-checking bench for sdram_wr_burst_sched
module tb_sdram_wr_burst_sched;
   import sdram_wr_pkg::*;

   localparam int DW   = 16;
   localparam int NW   = 8;
   localparam int AW   = 24;
   localparam int BL   = 8;
   localparam int TO   = 64;
   localparam int BASE = 0;
   localparam int TOP  = 31;

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_MOVE = 2;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          enable_i, flush_i, fifo_empty_i, fifo_underrun_i;
   logic [NW-1:0] fifo_data_num_i;
   logic          fifo_rd_en_o;
   logic [DW-1:0] fifo_rd_data_i;
   logic          sdram_wr_req_o, sdram_wr_ack_i;
   logic [AW-1:0] sdram_wr_addr_o;
   logic [NW-1:0] sdram_wr_len_o;
   logic          sdram_wr_data_req_i;
   logic [DW-1:0] sdram_wr_data_o;
   logic          sdram_wr_data_vld_o, busy_o, err_o;

   always #5 sys_clk = ~sys_clk;

   sdram_wr_burst_sched #(
      .DATA_W(DW), .NUM_W(NW), .BURST_LEN(BL), .TIMEOUT(TO), .ADDR_W(AW),
      .ADDR_BASE(24'(BASE)), .ADDR_TOP(24'(TOP))
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .enable_i(enable_i), .flush_i(flush_i),
      .fifo_empty_i(fifo_empty_i), .fifo_data_num_i(fifo_data_num_i),
      .fifo_underrun_i(fifo_underrun_i), .fifo_rd_en_o(fifo_rd_en_o),
      .fifo_rd_data_i(fifo_rd_data_i), .sdram_wr_req_o(sdram_wr_req_o),
      .sdram_wr_ack_i(sdram_wr_ack_i), .sdram_wr_addr_o(sdram_wr_addr_o),
      .sdram_wr_len_o(sdram_wr_len_o), .sdram_wr_data_req_i(sdram_wr_data_req_i),
      .sdram_wr_data_o(sdram_wr_data_o), .sdram_wr_data_vld_o(sdram_wr_data_vld_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   bit force_empty = 0;
   bit model_on = 0;

   // Reference model: burst phase, words left to pop, ring address, idle timer, pending flush.
   int m_phase, m_left, m_len, m_addr, m_ring, m_timer;
   bit m_flush, m_vld, m_err;

   typedef struct {
      int cnt; bit en; bit fl; int cyc; bit want_req; int want_len;
   } vec_t;
   typedef struct {
      int a; int l; int b; int t; int want;
   } wrap_t;

   task automatic chk(string name, longint act, longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic sync_fifo();
      fifo_data_num_i = NW'(fifo_q.size());
      fifo_empty_i    = force_empty || (fifo_q.size() == 0);
   endtask

   task automatic push(int n);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = DW'($urandom);
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      sync_fifo();
   endtask

   function automatic bit model_rd();
      return (m_phase == P_MOVE) && sdram_wr_data_req_i && (m_left > 0);
   endfunction

   task automatic compare();
      chk("req", sdram_wr_req_o, m_phase == P_WAIT);
      chk("busy", busy_o, m_phase != P_IDLE);
      chk("rd_en", fifo_rd_en_o, model_rd());
      chk("vld", sdram_wr_data_vld_o, m_vld);
      chk("err", err_o, m_err);
      if (m_phase == P_WAIT) begin
         chk("addr", sdram_wr_addr_o, m_addr);
         chk("len", sdram_wr_len_o, m_len);
      end
      if (m_vld && exp_q.size() > 0) chk("data", sdram_wr_data_o, exp_q.pop_front());
   endtask

   task automatic start_burst(int n);
      m_phase = P_WAIT;
      m_len   = n;
      m_left  = n;
      m_addr  = m_ring;
   endtask

   task automatic model_update();
      bit fl, rd;
      int cnt;
      rd  = model_rd();
      fl  = m_flush || flush_i;
      cnt = fifo_data_num_i;
      if (sys_rst) begin
         m_phase = P_IDLE; m_ring = BASE; m_timer = 0; m_flush = 0;
         m_err = 0; m_vld = 0; m_left = 0;
         return;
      end
      m_err = m_err || fifo_underrun_i || (rd && fifo_empty_i)
            || (sdram_wr_ack_i && m_phase != P_WAIT);
      case (m_phase)
         P_IDLE: begin
            if (!enable_i) begin
               m_timer = 0; m_flush = fl;
            end else if (cnt >= BL) begin
               start_burst(BL); m_flush = fl;
            end else if ((fl || m_timer == TO - 1) && cnt > 0) begin
               start_burst(cnt); m_timer = 0; m_flush = 0;
            end else if (cnt > 0) begin
               m_timer++; m_flush = fl;
            end else begin
               m_timer = 0; m_flush = 0;
            end
         end
         P_WAIT: begin
            m_flush = fl;
            if (sdram_wr_ack_i) m_phase = P_MOVE;
         end
         default: begin
            m_flush = fl;
            if (m_left == 0 && m_vld) begin
               m_phase = P_IDLE;
               m_ring  = BASE + (m_ring - BASE + m_len) % (TOP - BASE + 1);
            end
            if (rd) m_left--;
         end
      endcase
      m_vld = rd;
   endtask

   task automatic step();
      bit pop, was_rst;
      #1;
      if (model_on) compare();
      pop     = fifo_rd_en_o;
      was_rst = sys_rst;
      model_update();
      @(posedge sys_clk);
      #1;
      if (pop && fifo_q.size() > 0) fifo_rd_data_i = fifo_q.pop_front();
      if (was_rst) exp_q = fifo_q;
      flush_i = 0;
      sdram_wr_ack_i = 0;
      fifo_underrun_i = 0;
      sync_fifo();
   endtask

   task automatic do_reset();
      fifo_q.delete();
      exp_q.delete();
      force_empty = 0;
      sdram_wr_data_req_i = 0;
      sync_fifo();
      sys_rst = 1;
      step();
      sys_rst = 0;
   endtask

   task automatic serve(input int ack_dly, input int mode, input bit emp,
                        output int a, output int l, output int waited, output int nv);
      int n;
      a = -1; l = -1; waited = 0; nv = 0;
      while (!sdram_wr_req_o && waited < 300) begin
         step();
         waited++;
      end
      chk("req_seen", sdram_wr_req_o, 1);
      if (!sdram_wr_req_o) return;
      a = int'(sdram_wr_addr_o);
      l = int'(sdram_wr_len_o);
      repeat (ack_dly) step();
      chk("req_held", sdram_wr_req_o, 1);
      sdram_wr_ack_i = 1;
      step();
      n = 0;
      while (busy_o && n < 300) begin
         sdram_wr_data_req_i = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom);
         force_empty = emp && (n == 0);
         sync_fifo();
         step();
         n++;
         if (sdram_wr_data_vld_o) nv++;
      end
      force_empty = 0;
      sdram_wr_data_req_i = 0;
      sync_fifo();
      chk("burst_done", busy_o, 0);
   endtask

   vec_t  vecs[11];
   wrap_t wraps[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a, l, w, nv, nreq;
      vecs = '{
         '{20, 1'b1, 1'b0,  1, 1'b1, 8}, '{ 8, 1'b1, 1'b0,  1, 1'b1, 8},
         '{ 7, 1'b1, 1'b0,  1, 1'b0, 0}, '{ 7, 1'b1, 1'b1,  1, 1'b1, 7},
         '{ 9, 1'b1, 1'b1,  1, 1'b1, 8}, '{ 3, 1'b1, 1'b0, 63, 1'b0, 0},
         '{ 3, 1'b1, 1'b0, 64, 1'b1, 3}, '{ 0, 1'b1, 1'b1,  1, 1'b0, 0},
         '{50, 1'b0, 1'b0, 10, 1'b0, 0}, '{ 1, 1'b1, 1'b1,  1, 1'b1, 1},
         '{ 0, 1'b1, 1'b0, 80, 1'b0, 0}
      };
      wraps = '{
         '{8, 8, 0, 15, 0}, '{0, 8, 0, 15, 8}, '{14, 4, 8, 15, 10}, '{12, 4, 8, 15, 8},
         '{11, 4, 8, 15, 15}, '{28, 8, 0, 31, 4}, '{100, 5, 0, 'hFFFFFF, 105},
         '{'hFFFFFC, 8, 0, 'hFFFFFF, 4}
      };

      sys_rst = 1; enable_i = 0; flush_i = 0; fifo_underrun_i = 0;
      sdram_wr_ack_i = 0; sdram_wr_data_req_i = 0; fifo_rd_data_i = '0;
      sync_fifo();
      step();
      model_on = 1;

      foreach (wraps[i])
         chk($sformatf("wrap%0d", i),
             ring_next(wraps[i].a, wraps[i].l, wraps[i].b, wraps[i].t), wraps[i].want);

      foreach (vecs[i]) begin
         do_reset();
         push(vecs[i].cnt);
         enable_i = vecs[i].en;
         for (int c = 0; c < vecs[i].cyc; c++) begin
            flush_i = vecs[i].fl && (c == 0);
            step();
         end
         chk($sformatf("vec%0d_req", i), sdram_wr_req_o, vecs[i].want_req);
         if (vecs[i].want_req) begin
            chk($sformatf("vec%0d_len", i), sdram_wr_len_o, vecs[i].want_len);
            chk($sformatf("vec%0d_addr", i), sdram_wr_addr_o, 0);
         end
      end

      // Reset with 20 words queued, then two full bursts and a timeout partial.
      fifo_q.delete(); exp_q.delete(); push(20);
      enable_i = 1; sys_rst = 1;
      step();
      chk("rst_req", sdram_wr_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_vld", sdram_wr_data_vld_o, 0);
      chk("rst_rd_en", fifo_rd_en_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_addr", sdram_wr_addr_o, 0);
      chk("rst_len", sdram_wr_len_o, 0);
      sys_rst = 0;
      serve(0, 0, 0, a, l, w, nv);
      chk("a1_addr", a, 0); chk("a1_len", l, 8); chk("a1_wait", w, 1); chk("a1_vld", nv, 8);
      serve(0, 0, 0, a, l, w, nv);
      chk("a2_addr", a, 8); chk("a2_len", l, 8); chk("a2_wait", w, 1);
      serve(0, 0, 0, a, l, w, nv);
      chk("a3_addr", a, 16); chk("a3_len", l, 4); chk("a3_wait", w, 64); chk("a3_vld", nv, 4);
      push(16);
      serve(0, 2, 0, a, l, w, nv);
      chk("a4_addr", a, 20);
      serve(0, 2, 0, a, l, w, nv);
      chk("a5_addr", a, 28);
      push(8);
      serve(0, 0, 0, a, l, w, nv);
      chk("a6_wrap_addr", a, 4);

      // Flush of a short queue, then flush with nothing queued is discarded.
      do_reset();
      push(3); enable_i = 1;
      step();
      flush_i = 1;
      step();
      chk("fl_req", sdram_wr_req_o, 1);
      chk("fl_len", sdram_wr_len_o, 3);
      serve(0, 0, 0, a, l, w, nv);
      chk("fl_vld", nv, 3);
      flush_i = 1;
      nreq = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (c == 50) push(2);
         if (sdram_wr_req_o) nreq++;
      end
      chk("fl_stale_req", nreq, 0);

      // Delayed grant and alternating data requests.
      do_reset();
      push(8); enable_i = 1;
      serve(10, 1, 0, a, l, w, nv);
      chk("dly_addr", a, 0); chk("dly_len", l, 8); chk("dly_vld", nv, 8);

      // Sticky error sources.
      do_reset();
      sdram_wr_ack_i = 1;
      step();
      chk("err_ack_idle", err_o, 1);
      repeat (5) step();
      chk("err_sticky", err_o, 1);
      do_reset();
      chk("err_cleared", err_o, 0);
      push(8);
      serve(0, 0, 1, a, l, w, nv);
      chk("err_pop_empty", err_o, 1);
      chk("err_pop_vld", nv, 8);
      do_reset();
      fifo_underrun_i = 1;
      step();
      chk("err_underrun", err_o, 1);

      // Reset in the middle of a transfer, then disabled with a deep queue.
      do_reset();
      push(8); enable_i = 1;
      nv = 0;
      for (int c = 0; c < 20 && !sdram_wr_req_o; c++) step();
      sdram_wr_ack_i = 1;
      step();
      sdram_wr_data_req_i = 1;
      for (int c = 0; c < 20 && nv < 3; c++) begin
         step();
         if (sdram_wr_data_vld_o) nv++;
      end
      chk("mid_words", nv, 3);
      sys_rst = 1;
      step();
      chk("mid_busy", busy_o, 0);
      chk("mid_req", sdram_wr_req_o, 0);
      chk("mid_vld", sdram_wr_data_vld_o, 0);
      chk("mid_rd_en", fifo_rd_en_o, 0);
      chk("mid_len", sdram_wr_len_o, 0);
      sys_rst = 0; sdram_wr_data_req_i = 0; enable_i = 0;
      push(50 - fifo_q.size());
      nreq = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (sdram_wr_req_o) nreq++;
      end
      chk("dis_req", nreq, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (fifo_q.size() < 100 && $urandom_range(0, 3) == 0) push($urandom_range(1, 3));
         enable_i            = ($urandom_range(0, 15) != 0);
         flush_i             = ($urandom_range(0, 40) == 0);
         sdram_wr_ack_i      = sdram_wr_req_o && ($urandom_range(0, 3) == 0);
         sdram_wr_data_req_i = 1'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
